// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO registers.
// MULT/MULTU/DIV/DIVU take 33 cycles: 32 shift iterations plus one sign-fix cycle.
module muldiv_unit (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cancel_i,
    input  logic        hi_we_i,
    input  logic        lo_we_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] acc_q, acc_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        in_signed, a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum, div_trial;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        in_signed = ~op_i[0];
        a_neg     = in_signed & a_i[31];
        b_neg     = in_signed & b_i[31];
        mag_a     = a_neg ? (32'd0 - a_i) : a_i;
        mag_b     = b_neg ? (32'd0 - b_i) : b_i;

        // acc holds {partial product, remaining multiplier} for multiply,
        // and {partial remainder, dividend/quotient bits} for divide.
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        div_trial = acc_q[63:31] - {1'b0, opnd_q};

        prod_fix  = neg_res_q ? (64'd0 - acc_q) : acc_q;
        quo_fix   = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_fix   = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (hi_we_i) hi_d = wdata_i;
                if (lo_we_i) lo_d = wdata_i;
                if (start_i && !cancel_i) begin
                    op_d      = op_i;
                    a_d       = a_i;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = 5'd0;
                    state_d   = RUN;
                    if (op_i[1]) begin
                        opnd_d = mag_b;
                        acc_d  = {32'd0, mag_a};
                    end else begin
                        opnd_d = mag_a;
                        acc_d  = {32'd0, mag_b};
                    end
                end
            end
            RUN: begin
                if (op_q[1]) begin
                    // Restoring step: keep the subtraction only if it did not borrow.
                    if (!div_trial[32]) acc_d = {div_trial[31:0], acc_q[30:0], 1'b1};
                    else                acc_d = {acc_q[62:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIX;
                if (cancel_i) begin
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!cancel_i) begin
                    done_d = 1'b1;
                    if (!op_q[1]) begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end else if (opnd_q == 32'd0) begin
                        hi_d = a_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            op_q      <= 2'd0;
            a_q       <= 32'd0;
            opnd_q    <= 32'd0;
            acc_q     <= 64'd0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded bench for muldiv_unit: driver pushes expected {HI,LO}, monitor checks on done.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        cancel;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    muldiv_unit dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .cancel_i (cancel),
        .hi_we_i  (hi_we),
        .lo_we_i  (lo_we),
        .wdata_i  (wdata),
        .busy_o   (busy),
        .done_o   (done),
        .hi_o     (hi),
        .lo_o     (lo)
    );

    always #5 clk = ~clk;

    // Reference model: plain 64-bit arithmetic, returns {HI, LO}.
    function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        case (mop)
            2'b00: begin p = sa * sb; return p; end
            2'b01: begin p = {32'd0, ma} * {32'd0, mb}; return p; end
            2'b10: begin
                if (mb == 32'd0) return {ma, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (mb == 32'd0) return {ma, 32'hFFFF_FFFF};
                return {ma % mb, ma / mb};
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got hi=%h lo=%h want no done", hi, lo);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({hi, lo} !== e) begin
                    errors++;
                    $display("FAIL result: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e[63:32], e[31:0]);
                end else begin
                    $display("done: hi=%h lo=%h ok", hi, lo);
                end
            end
        end
    end

    task automatic start_only(input logic [1:0] sop, input logic [31:0] sa, input logic [31:0] sb);
        @(negedge clk);
        start = 1'b1; op = sop; a = sa; b = sb;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic mt(input logic is_hi, input logic [31:0] v);
        @(negedge clk);
        hi_we = is_hi; lo_we = ~is_hi; wdata = v;
        @(posedge clk);
        #1 hi_we = 1'b0; lo_we = 1'b0;
    endtask

    // Issue an op, push the model result and time the completion.
    task automatic issue(input logic [1:0] sop, input logic [31:0] sa, input logic [31:0] sb, input bit poke);
        int cycles;
        bit busy_bad;
        exp_q.push_back(model(sop, sa, sb));
        $display("issue op=%0d a=%h b=%h", sop, sa, sb);
        start_only(sop, sa, sb);
        cycles = 0;
        busy_bad = 1'b0;
        while (!done && cycles < 40) begin
            if (!busy) busy_bad = 1'b1;
            if (poke && cycles == 5) begin
                start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
                a = 32'd0; b = 32'd1; op = 2'b01;
            end
            if (poke && cycles == 6) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            @(posedge clk);
            #1 cycles++;
        end
        check("latency", 64'(cycles), 64'd33);
        check("busy_during_op", 64'(busy_bad), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);
        rst_n = 1'b1;

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        issue(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        issue(2'b11, 32'h1234, 32'd0, 1'b0);
        check("divu_by_zero", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);

        mt(1'b1, 32'hAAAA);
        check("mthi", 64'(hi), 64'hAAAA);
        mt(1'b0, 32'h5555);
        check("mtlo", 64'(lo), 64'h5555);

        issue(2'b11, 32'd100, 32'd7, 1'b1);
        check("busy_ignores", {hi, lo}, {32'd2, 32'd14});

        // Cancel at E10 leaves preloaded HI/LO untouched.
        mt(1'b1, 32'd1);
        mt(1'b0, 32'd2);
        start_only(2'b01, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        #1 cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        repeat (30) @(posedge clk);
        #1 check("cancel_hilo", {hi, lo}, {32'd1, 32'd2});
        issue(2'b01, 32'd3, 32'd4, 1'b0);
        check("restart", {hi, lo}, 64'd12);

        // Reset at E20 abandons the op.
        start_only(2'b00, 32'd7, 32'd9);
        repeat (19) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("midreset_hilo", {hi, lo}, 64'd0);
        check("midreset_busy_done", {62'd0, busy, done}, 64'd0);
        repeat (20) @(posedge clk);
        issue(2'b00, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            logic [1:0] rop;
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            issue(rop, ra, rb, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1 check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS execute stage, owning the architectural HI/LO registers. It consumes the `a`/`b` operand pair produced by the register-file read stage and executes MULT, MULTU, DIV and DIVU as 33-cycle operations. It serves MFHI/MFLO reads and MTHI/MTLO writes. It asserts `busy` so the pipeline control can stall on HI/LO hazards.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  request a new operation; sampled only in IDLE
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  32  operand A (multiplicand / dividend)
- b  in  32  operand B (multiplier / divisor)
- cancel  in  1  pipeline flush; aborts an in-flight operation
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  32  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; HI/LO just updated by an operation
- hi  out  32  HI register (registered)
- lo  out  32  LO register (registered)

## Operation
- States: IDLE, RUN, FIX.
- **IDLE:**
  - If `start` is high, latch `a`, `b` and `op`, record sign flags, and load magnitudes (`|x|` for signed ops, raw for unsigned). Clear the 5-bit iteration counter and go to RUN.
  - Without `start`, `hi_we`/`lo_we` write `wdata` into HI/LO at that edge.
  - Simultaneous `start` and `hi_we`/`lo_we`: both take effect. The operation result overwrites HI/LO at completion.
- **RUN:** one iteration per cycle, 32 iterations (counter 0..31); counter wraps to 0 on leaving RUN, then go to FIX.
  - Multiply: radix-2 shift-add on magnitudes into a 64-bit accumulator.
  - Divide: restoring division on magnitudes, producing a 32-bit quotient and a 32-bit remainder.
- **FIX:** applies sign correction, writes HI/LO, pulses `done`, returns to IDLE.
  - Signed multiply: negate the 64-bit product if operand signs differ. HI = product[63:32], LO = product[31:0].
  - Signed divide: negate the quotient if signs differ; the remainder takes the dividend's sign. LO = quotient, HI = remainder.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This is truncation of the magnitude result; no trap.
  - Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=original `a`. Latency is unchanged.
- `hi_we`/`lo_we` while `busy` are ignored. `start` while `busy` is ignored; no queueing.
- `cancel` in RUN or FIX: return to IDLE at that edge. HI/LO are unchanged and `done` is not pulsed. `cancel` in IDLE has no effect, and `start` in the same cycle is ignored.
- `hi`/`lo` always reflect the registers; there is no bypass of in-flight results.

## Timing
- Reset values (edge with `rst`=0):
  - state IDLE, counter 0
  - `busy`=0, `done`=0
  - `hi`=0, `lo`=0
  - Reset mid-operation abandons it and clears HI/LO.
- Let E0 be the edge that accepts `start`:
  - `busy`=1 from after E0 until after E33.
  - RUN iterations occur on edges E1..E32; FIX occurs on edge E33.
  - After E33: `hi`/`lo` hold the result, `done`=1 for exactly one cycle, `busy`=0.
  - Total latency is 33 cycles, identical for all ops and for divide-by-zero.
- A new `start` is accepted in the cycle after E33, so the earliest back-to-back acceptance is E34.
- MTHI/MTLO latency: 1 cycle; the value is visible on `hi`/`lo` after the writing edge.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> `done` pulses 33 cycles after the start edge; HI=0xFFFFFFFE, LO=0x00000001; `busy` high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=0x1234 b=0 -> LO=0xFFFFFFFF, HI=0x1234 after 33 cycles. DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0xAAAA / MTLO 0x5555 in IDLE -> visible next cycle. Start DIVU 100/7, then assert `start`, `hi_we` and `lo_we` mid-RUN -> all ignored; final HI=2, LO=14.
- Preload HI=1, LO=2, start MULTU 3*4, then `cancel` at E10 -> `busy` low next cycle, no `done`, HI=1, LO=2. Restart immediately -> HI=0, LO=12.
- Start MULT, then assert `rst` low at E20 -> HI=0, LO=0, `busy`=0, `done`=0. A fresh op completes normally afterwards.
